// File: rtl/asrm_mem_seq_if.sv
// RAM-side request/acknowledge bus between the asrm memory sequencer (master)
// and a memory of arbitrary latency (slave).
interface asrm_mem_seq_if #(
  parameter int wordsize = 16
) ();
  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_wdata;
  logic                mem_we;
  logic                mem_req;
  logic                mem_ack;
  logic [wordsize-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/asrm_mem_seq.sv
// CPU<->RAM access sequencer for the asrm core: fetches one instruction, then
// runs at most one data access (load/store/push/pop/call/ret) over a req/ack bus.
module asrm_mem_seq #(
  parameter int wordsize    = 16,
  parameter int INSTR_WIDTH = 8,
  parameter int TIMEOUT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [wordsize-1:0]    workingRegister,
  input  logic [wordsize-1:0]    programCounter,
  input  logic [wordsize-1:0]    stackPointer,
  input  logic [wordsize-1:0]    otherRegister,
  input  logic                   op_valid,
  input  logic [2:0]             op,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [wordsize-1:0]    out,
  output logic                   done,
  output logic                   busy,
  output logic                   bus_error,
  asrm_mem_seq_if.master         mem
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_CALL  = 3'd5;
  localparam logic [2:0] OP_RET   = 3'd6;
  localparam logic [2:0] OP_NOP7  = 3'd7;

  // The counter only has to reach TIMEOUT-1; the cycle after that is the timeout.
  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [2:0]          op_q;
  logic                req_q;
  logic                we_q;
  logic [wordsize-1:0] addr_q;
  logic [wordsize-1:0] wdata_q;
  logic [wordsize-1:0] wr_q;
  logic [TW-1:0]       to_cnt;

  logic                ack_hit;
  logic                to_hit;
  logic                op_access;
  logic                op_read;
  logic [wordsize-1:0] acc_addr;
  logic                acc_we;
  logic [wordsize-1:0] acc_wdata;

  assign ack_hit   = req_q && mem.mem_ack;
  // Ack in the final allowed cycle takes priority over the timeout.
  assign to_hit    = (TIMEOUT > 0) && req_q && !mem.mem_ack && (to_cnt == TO_LAST);
  assign op_access = (op != OP_NONE) && (op != OP_NOP7);
  assign op_read   = (op_q == OP_LOAD) || (op_q == OP_POP) || (op_q == OP_RET);

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_req   = req_q;

  // Data-access address/write data, decoded from the CPU registers at EXEC exit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_addr  = otherRegister;
    acc_we    = 1'b0;
    acc_wdata = '0;
    case (op)
      OP_STORE: begin
        acc_we    = 1'b1;
        acc_wdata = workingRegister;
      end
      OP_PUSH: begin
        acc_addr  = stackPointer;
        acc_we    = 1'b1;
        acc_wdata = workingRegister;
      end
      OP_POP, OP_RET: acc_addr = stackPointer - wordsize'(1);
      OP_CALL: begin
        acc_addr  = stackPointer;
        acc_we    = 1'b1;
        acc_wdata = programCounter;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (ack_hit) state_next = S_EXEC;
      S_EXEC:  if (op_valid) state_next = op_access ? S_DATA : S_FETCH;
      S_DATA:  if (ack_hit || to_hit) state_next = S_DONE;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      op_q        <= OP_NONE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= '0;
      to_cnt      <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      out         <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      state       <= state_next;
      busy        <= (state_next != S_EXEC);
      done        <= (state == S_DATA) && (state_next == S_DONE);
      instr_valid <= (state == S_FETCH) && ack_hit;
      to_cnt      <= (req_q && !mem.mem_ack && !to_hit) ? to_cnt + TW'(1) : '0;

      case (state)
        S_FETCH: begin
          // Each access opens with a req-low cycle, which also spaces back-to-back requests.
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= programCounter;
            wdata_q <= '0;
          end else if (ack_hit) begin
            req_q       <= 1'b0;
            instruction <= mem.mem_rdata[INSTR_WIDTH-1:0];
          end else if (to_hit) begin
            req_q     <= 1'b0;
            bus_error <= 1'b1;
          end
        end
        S_EXEC: begin
          if (op_valid && op_access) begin
            op_q    <= op;
            wr_q    <= workingRegister;
            addr_q  <= acc_addr;
            we_q    <= acc_we;
            wdata_q <= acc_wdata;
          end
        end
        S_DATA: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (ack_hit) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            out   <= op_read ? mem.mem_rdata : wr_q;
          end else if (to_hit) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            bus_error <= 1'b1;
            out       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asrm_mem_seq.sv
// Directed bench for asrm_mem_seq (TIMEOUT=4): fetch, push/pop/call/store/load,
// no-op ops, timeouts on fetch and data, and asynchronous reset mid-access.
module tb_asrm_mem_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] workingRegister;
  logic [15:0] programCounter;
  logic [15:0] stackPointer;
  logic [15:0] otherRegister;
  logic        op_valid;
  logic [2:0]  op;
  logic [7:0]  instruction;
  logic        instr_valid;
  logic [15:0] out;
  logic        done;
  logic        busy;
  logic        bus_error;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned t0;

  asrm_mem_seq_if #(.wordsize(16)) bus ();

  asrm_mem_seq #(
    .wordsize   (16),
    .INSTR_WIDTH(8),
    .TIMEOUT    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .workingRegister(workingRegister),
    .programCounter (programCounter),
    .stackPointer   (stackPointer),
    .otherRegister  (otherRegister),
    .op_valid       (op_valid),
    .op             (op),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .out            (out),
    .done           (done),
    .busy           (busy),
    .bus_error      (bus_error),
    .mem            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
  endtask

  // Answers one RAM access after `waits` cycles without ack; returns one
  // negedge after the acknowledging edge.
  task automatic serve(input string tag, input int waits, input logic [15:0] rdata,
                       input logic [15:0] exp_addr, input logic exp_we, input logic [15:0] exp_wdata);
    bus.mem_ack = 1'b0;
    wait_req(tag);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
    check({tag, "_we"}, 32'(bus.mem_we), 32'(exp_we));
    if (exp_we) check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(exp_wdata));
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d", tag, i), 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, exp_addr}));
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
  endtask

  task automatic fetch(input string tag, input logic [15:0] pc, input logic [15:0] rdata, input int waits);
    programCounter = pc;
    serve(tag, waits, rdata, pc, 1'b0, 16'h0000);
    check({tag, "_iv"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(instruction), 32'(rdata[7:0]));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_iv_pulse"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    workingRegister = 16'h0000;
    programCounter  = 16'h0010;
    stackPointer    = 16'h0000;
    otherRegister   = 16'h0000;
    op_valid        = 1'b0;
    op              = 3'd0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 16'h0000;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({bus.mem_req, bus.mem_we, busy, done, instr_valid, bus_error}), 32'd0);
    check("rst_data", 32'({bus.mem_addr, out}), 32'd0);

    // Zero-wait fetch from PC=0x0010
    reset = 1'b1;
    t0 = cyc;
    serve("f1", 0, 16'h00A5, 16'h0010, 1'b0, 16'h0000);
    check("f1_lat", cyc - t0, 32'd2);
    check("f1_iv", 32'(instr_valid), 32'd1);
    check("f1_instr", 32'(instruction), 32'h00A5);
    check("f1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("f1_iv_pulse", 32'(instr_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("exec_idle", 32'({bus.mem_req, busy, done}), 32'd0);

    // Push with 3 wait states; op_valid held with a different op while busy
    stackPointer    = 16'h0100;
    workingRegister = 16'h1234;
    op              = 3'd3;
    op_valid        = 1'b1;
    @(negedge clk);
    t0 = cyc;
    op              = 3'd2;
    stackPointer    = 16'hDEAD;
    workingRegister = 16'h5555;
    check("push_busy", 32'(busy), 32'd1);
    serve("push", 3, 16'hFFFF, 16'h0100, 1'b1, 16'h1234);
    op_valid = 1'b0;
    op       = 3'd0;
    check("push_lat", cyc - t0, 32'd5);
    check("push_done", 32'(done), 32'd1);
    check("push_out", 32'(out), 32'h1234);
    check("push_no_err", 32'(bus_error), 32'd0);
    @(negedge clk);
    check("push_done_pulse", 32'({done, bus.mem_req}), 32'd0);
    fetch("f2", 16'h0020, 16'h0033, 0);

    // Pop from SP=0 wraps to 0xFFFF
    stackPointer = 16'h0000;
    op           = 3'd4;
    op_valid     = 1'b1;
    @(negedge clk);
    t0 = cyc;
    op_valid = 1'b0;
    serve("pop", 0, 16'hBEEF, 16'hFFFF, 1'b0, 16'h0000);
    check("pop_lat", cyc - t0, 32'd2);
    check("pop_done", 32'(done), 32'd1);
    check("pop_out", 32'(out), 32'hBEEF);
    @(negedge clk);
    check("pop_done_pulse", 32'(done), 32'd0);

    // Call pushes PC; CPU register changes during DATA must not leak in
    fetch("f3", 16'h0042, 16'h0044, 1);
    stackPointer    = 16'h0200;
    workingRegister = 16'h7777;
    op              = 3'd5;
    op_valid        = 1'b1;
    @(negedge clk);
    op_valid       = 1'b0;
    programCounter = 16'h0099;
    stackPointer   = 16'h0333;
    serve("call", 1, 16'h0000, 16'h0200, 1'b1, 16'h0042);
    check("call_done", 32'(done), 32'd1);
    check("call_out", 32'(out), 32'h7777);
    @(negedge clk);
    fetch("f4", 16'h0050, 16'h0055, 0);

    // op=0 and op=7 return to FETCH without a done pulse
    op       = 3'd0;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("op0_state", 32'({busy, done, bus.mem_req}), 32'b100);
    @(negedge clk);
    check("op0_refetch", 32'({done, bus.mem_req, bus.mem_we, bus.mem_addr}), 32'({3'b010, 16'h0050}));
    fetch("f5", 16'h0050, 16'h0066, 0);
    op       = 3'd7;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("op7_state", 32'({busy, done, bus.mem_req}), 32'b100);
    fetch("f6", 16'h0060, 16'h0077, 0);

    // Load with no ack: req held exactly 4 cycles, then DONE with out=0
    otherRegister = 16'h0300;
    op            = 3'd1;
    op_valid      = 1'b1;
    @(negedge clk);
    t0 = cyc;
    op_valid = 1'b0;
    wait_req("ld");
    check("ld_addr", 32'({bus.mem_we, bus.mem_addr}), 32'({1'b0, 16'h0300}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ld_wait%0d", i), 32'({bus.mem_req, bus_error}), 32'b10);
    end
    @(negedge clk);
    check("ld_to_lat", cyc - t0, 32'd5);
    check("ld_to_state", 32'({bus.mem_req, done, bus_error}), 32'b011);
    check("ld_to_out", 32'(out), 32'd0);
    @(negedge clk);
    check("ld_err_sticky", 32'({done, bus_error}), 32'b01);

    // Fetch timeout: req drops for one cycle, no instr_valid, then refetch
    programCounter = 16'h0070;
    wait_req("fto");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("fto_wait%0d", i), 32'(bus.mem_req), 32'd1);
    end
    @(negedge clk);
    check("fto_drop", 32'({bus.mem_req, instr_valid}), 32'd0);
    check("fto_instr_kept", 32'(instruction), 32'h0077);
    fetch("f7", 16'h0070, 16'h0088, 0);
    check("f7_err_sticky", 32'(bus_error), 32'd1);

    // Store, then a second store interrupted by reset while req is high
    otherRegister   = 16'h0400;
    workingRegister = 16'hAAAA;
    op              = 3'd2;
    op_valid        = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    serve("st1", 0, 16'h0000, 16'h0400, 1'b1, 16'hAAAA);
    check("st1_out", 32'({done, out}), 32'({1'b1, 16'hAAAA}));
    fetch("f8", 16'h0090, 16'h00C3, 0);
    otherRegister = 16'h0404;
    op_valid      = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    wait_req("st2");
    check("st2_we", 32'(bus.mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'({bus.mem_req, bus.mem_we, busy, done, instr_valid, bus_error}), 32'd0);
    check("rst_mid_data", 32'({bus.mem_addr, out}), 32'd0);
    check("rst_mid_instr", 32'(instruction), 32'd0);
    @(negedge clk);
    programCounter = 16'h0080;
    reset          = 1'b1;
    t0             = cyc;
    serve("f9", 0, 16'h0099, 16'h0080, 1'b0, 16'h0000);
    check("f9_lat", cyc - t0, 32'd2);
    check("f9_instr", 32'({instr_valid, instruction}), 32'({1'b1, 8'h99}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
